shift_rr_sequencer: RTL and testbench

Multi-cycle shift engine with a two-requester round-robin front end. It accepts a shift command (LSL, LSR, ASR or ROL) from one requester at a time. The shift runs one bit position per clock, for amt clocks. The result is returned with the requester id and reduction flags (AND, OR, XOR of the result). It is the shared sequencer in front of the shift/reduction datapath, so that several blocks can use one shifter.

---
 rtl/shift_rr_sequencer_pkg.sv | 21 ++
 rtl/shift_rr_sequencer_if.sv | 52 +++++
 rtl/shift_rr_sequencer_arb.sv | 35 +++
 rtl/shift_rr_sequencer.sv | 126 ++++++++++++
 tb/tb_shift_rr_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_rr_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_seq_pkg
// Description : Opcodes and FSM state encoding shared by the shift sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_seq_pkg;

    localparam logic [1:0] OP_LSL = 2'b00;
    localparam logic [1:0] OP_LSR = 2'b01;
    localparam logic [1:0] OP_ASR = 2'b10;
    localparam logic [1:0] OP_ROL = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/shift_rr_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : shift_rr_sequencer_if
// Description : Two-requester command bus plus result channel of the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface shift_rr_sequencer_if #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 3
);
    logic               i_Req0_Valid;
    logic [1:0]         i_Req0_Op;
    logic [WIDTH-1:0]   i_Req0_Data;
    logic [SHAMT_W-1:0] i_Req0_Amt;
    logic               o_Req0_Ready;

    logic               i_Req1_Valid;
    logic [1:0]         i_Req1_Op;
    logic [WIDTH-1:0]   i_Req1_Data;
    logic [SHAMT_W-1:0] i_Req1_Amt;
    logic               o_Req1_Ready;

    logic               o_Rsp_Valid;
    logic               i_Rsp_Ready;
    logic [WIDTH-1:0]   o_Rsp_Data;
    logic               o_Rsp_Id;
    logic               o_Rsp_And;
    logic               o_Rsp_Or;
    logic               o_Rsp_Xor;
    logic               o_Busy;

    modport slave (
        input  i_Req0_Valid, i_Req0_Op, i_Req0_Data, i_Req0_Amt,
        output o_Req0_Ready,
        input  i_Req1_Valid, i_Req1_Op, i_Req1_Data, i_Req1_Amt,
        output o_Req1_Ready,
        output o_Rsp_Valid, o_Rsp_Data, o_Rsp_Id, o_Rsp_And, o_Rsp_Or, o_Rsp_Xor,
        input  i_Rsp_Ready,
        output o_Busy
    );

    modport master (
        output i_Req0_Valid, i_Req0_Op, i_Req0_Data, i_Req0_Amt,
        input  o_Req0_Ready,
        output i_Req1_Valid, i_Req1_Op, i_Req1_Data, i_Req1_Amt,
        input  o_Req1_Ready,
        input  o_Rsp_Valid, o_Rsp_Data, o_Rsp_Id, o_Rsp_And, o_Rsp_Or, o_Rsp_Xor,
        output i_Rsp_Ready,
        input  o_Busy
    );
endinterface
`default_nettype wire

// File: rtl/shift_rr_sequencer_arb.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin arbiter; on a tie the side that did not
//               win last time is granted.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  wire logic       i_req0,
    input  wire logic       i_req1,
    input  wire logic       i_last,
    input  wire logic       i_enable,
    output logic [1:0]      o_grant,
    output logic            o_grant_id
);

    always_comb begin
        o_grant    = 2'b00;
        o_grant_id = 1'b0;
        if (i_enable) begin
            if (i_req0 && i_req1) begin
                o_grant_id = ~i_last;
                o_grant    = i_last ? 2'b01 : 2'b10;
            end else if (i_req0) begin
                o_grant_id = 1'b0;
                o_grant    = 2'b01;
            end else if (i_req1) begin
                o_grant_id = 1'b1;
                o_grant    = 2'b10;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/shift_rr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : shift_rr_sequencer
// Description : Round-robin fronted multi-cycle shifter (one bit per clock)
//               returning the result with requester id and reduction flags.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_rr_sequencer
    import shift_seq_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 3
) (
    input  wire logic           i_Clock,
    input  wire logic           i_Reset,
    shift_rr_sequencer_if.slave bus
);

    state_t             r_state;
    logic [WIDTH-1:0]   r_data;
    logic [SHAMT_W-1:0] r_count;
    logic [1:0]         r_op;
    logic               r_id;
    logic               r_last;
    logic               r_rsp_valid;
    logic               r_busy;

    logic [1:0]         w_grant;
    logic               w_grant_id;
    logic               w_enable;
    logic [WIDTH-1:0]   w_cmd_data;
    logic [1:0]         w_cmd_op;
    logic [SHAMT_W-1:0] w_cmd_amt;
    logic [WIDTH-1:0]   w_step;

    // Ready must stay low while reset is held, even though the state reads IDLE.
    assign w_enable = (r_state == S_IDLE) && !i_Reset;

    rr_arb2 u_arb (
        .i_req0     (bus.i_Req0_Valid),
        .i_req1     (bus.i_Req1_Valid),
        .i_last     (r_last),
        .i_enable   (w_enable),
        .o_grant    (w_grant),
        .o_grant_id (w_grant_id)
    );

    assign w_cmd_data = w_grant_id ? bus.i_Req1_Data : bus.i_Req0_Data;
    assign w_cmd_op   = w_grant_id ? bus.i_Req1_Op   : bus.i_Req0_Op;
    assign w_cmd_amt  = w_grant_id ? bus.i_Req1_Amt  : bus.i_Req0_Amt;

    always_comb begin
        w_step = r_data;
        case (r_op)
            OP_LSL:  w_step = {r_data[WIDTH-2:0], 1'b0};
            OP_LSR:  w_step = {1'b0, r_data[WIDTH-1:1]};
            OP_ASR:  w_step = {r_data[WIDTH-1], r_data[WIDTH-1:1]};
            OP_ROL:  w_step = {r_data[WIDTH-2:0], r_data[WIDTH-1]};
            default: w_step = r_data;
        endcase
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_state     <= S_IDLE;
            r_data      <= '0;
            r_count     <= '0;
            r_op        <= 2'b00;
            r_id        <= 1'b0;
            r_last      <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|w_grant) begin
                        r_data <= w_cmd_data;
                        r_op   <= w_cmd_op;
                        r_id   <= w_grant_id;
                        r_last <= w_grant_id;
                        r_busy <= 1'b1;
                        if (w_cmd_amt == '0) begin
                            r_state     <= S_DONE;
                            r_rsp_valid <= 1'b1;
                        end else begin
                            r_count <= w_cmd_amt;
                            r_state <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    r_data  <= w_step;
                    r_count <= r_count - 1'b1;
                    if (r_count == SHAMT_W'(1)) begin
                        r_state     <= S_DONE;
                        r_rsp_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.i_Rsp_Ready) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_Req0_Ready = w_grant[0];
    assign bus.o_Req1_Ready = w_grant[1];
    assign bus.o_Rsp_Valid  = r_rsp_valid;
    assign bus.o_Rsp_Data   = r_data;
    assign bus.o_Rsp_Id     = r_id;
    assign bus.o_Rsp_And    = &r_data;
    assign bus.o_Rsp_Or     = |r_data;
    assign bus.o_Rsp_Xor    = ^r_data;
    assign bus.o_Busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_shift_rr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_rr_sequencer
// Description : Scoreboard bench for shift_rr_sequencer with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_rr_sequencer;
    import shift_seq_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    shift_rr_sequencer_if #(.WIDTH(8), .SHAMT_W(3)) bus ();

    shift_rr_sequencer #(.WIDTH(8), .SHAMT_W(3)) dut (
        .i_Clock (clk),
        .i_Reset (rst),
        .bus     (bus)
    );

    logic       req_v  [2];
    logic [1:0] req_op [2];
    logic [7:0] req_d  [2];
    logic [2:0] req_a  [2];
    logic       rsp_rdy;

    assign bus.i_Req0_Valid = req_v[0];
    assign bus.i_Req0_Op    = req_op[0];
    assign bus.i_Req0_Data  = req_d[0];
    assign bus.i_Req0_Amt   = req_a[0];
    assign bus.i_Req1_Valid = req_v[1];
    assign bus.i_Req1_Op    = req_op[1];
    assign bus.i_Req1_Data  = req_d[1];
    assign bus.i_Req1_Amt   = req_a[1];
    assign bus.i_Rsp_Ready  = rsp_rdy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        logic       id;
        int         due;
    } exp_t;
    exp_t sb[$];

    bit [1:0] auto_en   = 2'b00;
    int       auto_rate = 100;
    int       rr_mode   = 0;   // 0: always ready, 1: random, 2: stalled

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference result straight from the shift definitions, whole amount at once.
    function automatic logic [7:0] model(logic [1:0] op, logic [7:0] d, int amt);
        logic [15:0] t;
        case (op)
            OP_LSL:  return (amt >= W) ? 8'h00 : 8'(d << amt);
            OP_LSR:  return (amt >= W) ? 8'h00 : 8'(d >> amt);
            OP_ASR:  return 8'($signed(d) >>> ((amt >= W) ? W - 1 : amt));
            default: begin
                t = {d, d} << (amt % W);
                return t[15:8];
            end
        endcase
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic m_last     = 1'b1;
    logic m_busy     = 1'b0;
    bit   first_seen = 1'b0;

    always @(negedge clk) begin : mon
        logic       r0, r1, v0, v1, win;
        logic [1:0] exp_r;
        exp_t       e;
        r0 = bus.o_Req0_Ready;
        r1 = bus.o_Req1_Ready;
        v0 = req_v[0];
        v1 = req_v[1];
        if (rst) begin
            check("rst_outputs",
                  32'({bus.o_Rsp_Valid, bus.o_Busy, r0, r1, bus.o_Rsp_And, bus.o_Rsp_Or, bus.o_Rsp_Xor}), 32'd0);
            check("rst_data", 32'(bus.o_Rsp_Data), 32'd0);
            sb.delete();
            m_busy     = 1'b0;
            m_last     = 1'b1;
            first_seen = 1'b0;
        end else begin
            if (!m_busy) begin
                win   = (v0 && v1) ? ~m_last : v1 && !v0;
                exp_r = (v0 || v1) ? (win ? 2'b10 : 2'b01) : 2'b00;
                if (v0 || v1) check("grant", 32'({r1, r0}), 32'(exp_r));
            end else if (v0 || v1) begin
                check("ready_while_busy", 32'({r1, r0}), 32'd0);
            end
            check("busy", 32'(bus.o_Busy), 32'(m_busy));

            if (bus.o_Rsp_Valid) begin
                if (sb.size() == 0) begin
                    check("rsp_unexpected", 32'(bus.o_Rsp_Valid), 32'd0);
                end else begin
                    e = sb[0];
                    if (!first_seen) check("rsp_latency", 32'(cyc), 32'(e.due));
                    first_seen = 1'b1;
                    check("rsp_data", 32'(bus.o_Rsp_Data), 32'(e.data));
                    check("rsp_id", 32'(bus.o_Rsp_Id), 32'(e.id));
                    check("rsp_flags", 32'({bus.o_Rsp_And, bus.o_Rsp_Or, bus.o_Rsp_Xor}),
                          32'({&e.data, |e.data, ^e.data}));
                    if (rsp_rdy) begin
                        void'(sb.pop_front());
                        first_seen = 1'b0;
                    end
                end
            end else if (sb.size() > 0 && !first_seen && cyc == sb[0].due) begin
                check("rsp_late", 32'(bus.o_Rsp_Valid), 32'd1);
            end

            if (r0 || r1) begin
                win    = r1;
                e.data = model(req_op[win], req_d[win], int'(req_a[win]));
                e.id   = win;
                e.due  = cyc + int'(req_a[win]) + 1;
                sb.push_back(e);
                m_last = win;
                m_busy = 1'b1;
            end
            if (bus.o_Rsp_Valid && rsp_rdy) m_busy = 1'b0;
        end
    end

    // ---------------- drivers ----------------
    task automatic drive_req(input int n);
        bit acc;
        forever begin
            @(negedge clk);
            acc = (n == 0) ? bus.o_Req0_Ready : bus.o_Req1_Ready;
            @(posedge clk);
            #1;
            if (auto_en[n] && (acc || !req_v[n] || $urandom_range(0, 15) == 0)) begin
                if ($urandom_range(1, 100) <= auto_rate) begin
                    req_v[n]  = 1'b1;
                    req_op[n] = 2'($urandom_range(0, 3));
                    req_d[n]  = 8'($urandom);
                    req_a[n]  = 3'($urandom_range(0, 7));
                end else begin
                    req_v[n] = 1'b0;
                end
            end
        end
    endtask

    initial begin
        rsp_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rsp_rdy = (rr_mode == 0) ? 1'b1 : (rr_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    task automatic set_cmd(int n, logic [1:0] op, logic [7:0] d, logic [2:0] a);
        req_op[n] = op;
        req_d[n]  = d;
        req_a[n]  = a;
        req_v[n]  = 1'b1;
    endtask

    task automatic await_accept(int n, string name);
        bit got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            got = (n == 0) ? bus.o_Req0_Ready : bus.o_Req1_Ready;
        end
        check({name, "_accept"}, 32'(got), 32'd1);
        @(posedge clk);
        #1;
        req_v[n] = 1'b0;
    endtask

    task automatic send(int n, logic [1:0] op, logic [7:0] d, logic [2:0] a, string name);
        @(posedge clk);
        #1;
        set_cmd(n, op, d, a);
        await_accept(n, name);
    endtask

    task automatic wait_rsp(string name, logic [7:0] d, logic id, logic [2:0] f);
        bit got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = bus.o_Rsp_Valid;
        end
        check({name, "_valid"}, 32'(got), 32'd1);
        if (got) begin
            check({name, "_data"}, 32'(bus.o_Rsp_Data), 32'(d));
            check({name, "_id"}, 32'(bus.o_Rsp_Id), 32'(id));
            check({name, "_flags"}, 32'({bus.o_Rsp_And, bus.o_Rsp_Or, bus.o_Rsp_Xor}), 32'(f));
        end
    endtask

    task automatic drain(string name);
        bit done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            #1;
            done = !bus.o_Busy && sb.size() == 0 && !req_v[0] && !req_v[1];
        end
        check(name, 32'(done), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            req_v[i]  = 1'b0;
            req_op[i] = 2'b00;
            req_d[i]  = 8'h00;
            req_a[i]  = 3'd0;
        end
        fork
            drive_req(0);
            drive_req(1);
        join_none

        // Both requesters valid from reset: grants must alternate.
        auto_rate = 100;
        auto_en   = 2'b11;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (60) @(posedge clk);
        auto_en = 2'b00;
        #3;
        req_v[0] = 1'b0;
        req_v[1] = 1'b0;
        drain("drain_alternate");

        send(0, OP_LSL, 8'h96, 3'd1, "lsl1");
        wait_rsp("lsl1", 8'h2C, 1'b0, 3'b011);
        send(1, OP_ASR, 8'h90, 3'd2, "asr2");
        wait_rsp("asr2", 8'hE4, 1'b1, 3'b010);
        send(1, OP_LSR, 8'h90, 3'd2, "lsr2");
        wait_rsp("lsr2", 8'h24, 1'b1, 3'b010);
        send(0, OP_ROL, 8'h81, 3'd3, "rol3");
        wait_rsp("rol3", 8'h0C, 1'b0, 3'b010);
        send(0, OP_ROL, 8'h81, 3'd7, "rol7");
        wait_rsp("rol7", 8'hC0, 1'b0, 3'b010);
        send(0, OP_LSR, 8'hFF, 3'd0, "lsr0");
        wait_rsp("lsr0", 8'hFF, 1'b0, 3'b110);

        // Backpressure: result must hold and no command may be taken.
        rr_mode = 2;
        @(posedge clk);
        @(posedge clk);
        send(0, OP_LSR, 8'hFF, 3'd0, "bp");
        set_cmd(0, OP_ROL, 8'h81, 3'd1);
        wait_rsp("bp", 8'hFF, 1'b0, 3'b110);
        repeat (5) @(negedge clk);
        check("bp_hold_valid", 32'(bus.o_Rsp_Valid), 32'd1);
        check("bp_hold_data", 32'(bus.o_Rsp_Data), 32'hFF);
        rr_mode = 0;
        await_accept(0, "bp_next");
        wait_rsp("bp_next", 8'h03, 1'b0, 3'b010);

        // Asynchronous reset in the middle of a shift.
        send(0, OP_LSL, 8'h5A, 3'd5, "abort");
        @(posedge clk);
        @(posedge clk);
        #2;
        check("pre_reset_busy", 32'(bus.o_Busy), 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(bus.o_Rsp_Valid), 32'd0);
        check("async_rst_busy", 32'(bus.o_Busy), 32'd0);
        set_cmd(0, OP_ASR, 8'h80, 3'd1);
        set_cmd(1, OP_LSL, 8'h01, 3'd2);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        await_accept(0, "tie0");
        wait_rsp("tie0", 8'hC0, 1'b0, 3'b010);
        await_accept(1, "tie1");
        wait_rsp("tie1", 8'h04, 1'b1, 3'b011);
        drain("drain_directed");

        // Randomized traffic with random backpressure.
        auto_rate = 60;
        rr_mode   = 1;
        auto_en   = 2'b11;
        repeat (3000) @(posedge clk);
        auto_en = 2'b00;
        #3;
        req_v[0] = 1'b0;
        req_v[1] = 1'b0;
        rr_mode  = 0;
        drain("drain_random");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
